dmstatus_gen: RTL and testbench

//  Debug-module status encoder: aggregates live per-hart state and sticky event flags into the
//  32-bit dmstatus word returned on DMI reads. Counterpart of the dmstatus field decoder. Sits in
//  the debug module between the hart status interface and the DMI register read mux.

---
 rtl/dmstatus_gen.sv | 100 ++++++++++
 tb/tb_dmstatus_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dmstatus_gen.sv
// dmstatus_gen: folds live hart state, sticky havereset/resumeack flags and the
// authentication handshake into the dmstatus word captured on each DMI read.
module dmstatus_gen #(
  parameter int          NHARTS     = 4,
  parameter logic [3:0]  VERSION    = 4'd2,
  parameter logic        IMPEBREAK  = 1'b1,
  parameter logic        HASRSTHALT = 1'b0,
  parameter logic        AUTH_EN    = 1'b0,
  parameter logic [31:0] AUTH_KEY   = 32'hA5A5_5A5A,
  parameter int          AUTH_LAT   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dmactive_i,
  input  logic [NHARTS-1:0] hart_halted_i,
  input  logic [NHARTS-1:0] hart_running_i,
  input  logic [NHARTS-1:0] hart_unavail_i,
  input  logic [NHARTS-1:0] hart_reset_i,
  input  logic [NHARTS-1:0] hart_resumeack_i,
  input  logic [19:0]       hartsel_i,
  input  logic              hasel_i,
  input  logic [NHARTS-1:0] hawindow_i,
  input  logic              ackhavereset_i,
  input  logic              resumereq_i,
  input  logic              authdata_wr_i,
  input  logic [31:0]       authdata_i,
  input  logic              rd_req_i,
  output logic              rd_valid_o,
  output logic [31:0]       dmstat_reg_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t            r_state, w_state_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic              r_match, w_match_nxt, r_authd, w_authd_nxt;
  logic [NHARTS-1:0] r_havereset, r_resumeack, w_sel, w_hr_nxt, w_ra_nxt;
  logic              w_nonexist, w_any_sel, w_authd, w_authbusy;
  logic [4:0]        w_any, w_all;
  logic [11:0]       w_stat;
  logic [31:0]       w_word;
  logic              r_valid;
  logic [31:0]       r_word;
  always_comb begin
    w_nonexist = hartsel_i >= 20'(NHARTS);
    w_sel      = (w_nonexist ? '0 : NHARTS'(1) << hartsel_i) | (hasel_i ? hawindow_i : '0);
    w_any_sel  = |w_sel;
    w_any      = {|(r_resumeack & w_sel), |(r_havereset & w_sel), |(hart_unavail_i & w_sel),
                  |(hart_running_i & w_sel), |(hart_halted_i & w_sel)};
    w_all      = {&(r_resumeack | ~w_sel), &(r_havereset | ~w_sel), &(hart_unavail_i | ~w_sel),
                  &(hart_running_i | ~w_sel), &(hart_halted_i | ~w_sel)} & {5{w_any_sel}};
    w_stat     = {w_all[3], w_any[3], w_all[4], w_any[4], w_nonexist & ~w_any_sel, w_nonexist,
                  w_all[2], w_any[2], w_all[1], w_any[1], w_all[0], w_any[0]};
    w_authd    = AUTH_EN ? r_authd : 1'b1;
    w_authbusy = AUTH_EN && r_state == BUSY;
    w_word     = {9'b0, IMPEBREAK, 2'b0, w_authd ? w_stat : 12'b0, w_authd, w_authbusy,
                  HASRSTHALT, 1'b0, VERSION};
  end
  // set wins for havereset, clear wins for resumeack; an inactive DM forces both
  always_comb begin
    w_hr_nxt = dmactive_i ? (r_havereset & ~(ackhavereset_i ? w_sel : '0)) | hart_reset_i : '1;
    w_ra_nxt = dmactive_i ? (r_resumeack | hart_resumeack_i) & ~(resumereq_i ? w_sel : '0) : '0;
  end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_match_nxt = r_match;
    w_authd_nxt = r_authd;
    if (r_state == IDLE && authdata_wr_i && AUTH_EN) begin
      w_state_nxt = BUSY;
      w_cnt_nxt   = 8'(AUTH_LAT - 1);
      w_match_nxt = authdata_i == AUTH_KEY;
    end else if (r_state == BUSY) begin
      w_state_nxt = r_cnt == 8'd0 ? IDLE : BUSY;
      w_cnt_nxt   = r_cnt == 8'd0 ? r_cnt : r_cnt - 8'd1;
      w_authd_nxt = r_cnt == 8'd0 ? r_match : r_authd;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_match     <= 1'b0;
      r_authd     <= ~AUTH_EN;
      r_havereset <= '1;
      r_resumeack <= '0;
      r_valid     <= 1'b0;
      r_word      <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_match     <= w_match_nxt;
      r_authd     <= w_authd_nxt;
      r_havereset <= w_hr_nxt;
      r_resumeack <= w_ra_nxt;
      r_valid     <= rd_req_i;
      if (rd_req_i) r_word <= w_word;
    end
  end
  assign rd_valid_o   = r_valid;
  assign dmstat_reg_o = r_word;
endmodule

// File: tb/tb_dmstatus_gen.sv
// tb_dmstatus_gen: two DUTs (auth off / auth on) checked every cycle against a
// per-hart behavioural model, plus hand-computed literal expectations.
module tb_dmstatus_gen;
  logic        clk = 0, rst_n = 0, dmactive = 1;
  logic [3:0]  halted = 0, running = 0, unavail = 0, hreset = 0, hrack = 0, hawin = 0;
  logic [19:0] hartsel = 0;
  logic        hasel = 0, ack = 0, rreq = 0, awr = 0, rd = 0;
  logic [31:0] adata = 0;
  logic        a_valid, b_valid;
  logic [31:0] a_word, b_word;
  int          n_pass = 0, n_total = 0;
  logic [3:0]  m_hr = 4'hF, m_ra = 4'h0;
  bit          m_authd = 0, m_match = 0;
  int          m_left = 0;
  logic        ea_v = 0, eb_v = 0;
  logic [31:0] ea_w = 0, eb_w = 0;

  always #5 clk = ~clk;

  dmstatus_gen u_a (
    .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive), .hart_halted_i(halted),
    .hart_running_i(running), .hart_unavail_i(unavail), .hart_reset_i(hreset),
    .hart_resumeack_i(hrack), .hartsel_i(hartsel), .hasel_i(hasel), .hawindow_i(hawin),
    .ackhavereset_i(ack), .resumereq_i(rreq), .authdata_wr_i(awr), .authdata_i(adata),
    .rd_req_i(rd), .rd_valid_o(a_valid), .dmstat_reg_o(a_word));

  dmstatus_gen #(.AUTH_EN(1'b1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive), .hart_halted_i(halted),
    .hart_running_i(running), .hart_unavail_i(unavail), .hart_reset_i(hreset),
    .hart_resumeack_i(hrack), .hartsel_i(hartsel), .hasel_i(hasel), .hawindow_i(hawin),
    .ackhavereset_i(ack), .resumereq_i(rreq), .authdata_wr_i(awr), .authdata_i(adata),
    .rd_req_i(rd), .rd_valid_o(b_valid), .dmstat_reg_o(b_word));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    hreset = 0; hrack = 0; ack = 0; rreq = 0; awr = 0; rd = 0;
  endtask

  function automatic bit sel(input int i);
    return (hartsel == 20'(i)) || (hasel && hawin[i]);
  endfunction

  function automatic logic [31:0] model_word(input bit authd, input bit busy,
                                             input logic [3:0] hr, input logic [3:0] ra);
    logic [3:0]  f [5];
    int          pos [5];
    logic [31:0] w;
    int          nsel;
    bit          nonex;
    f[0] = halted; f[1] = running; f[2] = unavail; f[3] = hr; f[4] = ra;
    pos[0] = 8; pos[1] = 10; pos[2] = 12; pos[3] = 18; pos[4] = 16;
    w = 32'h0040_0002;
    nsel = 0;
    nonex = hartsel >= 20'd4;
    for (int i = 0; i < 4; i++) nsel += int'(sel(i));
    if (authd) begin
      for (int k = 0; k < 5; k++) begin
        bit any, all;
        any = 0;
        all = nsel > 0;
        for (int i = 0; i < 4; i++)
          if (sel(i)) begin
            if (f[k][i]) any = 1;
            else all = 0;
          end
        w[pos[k]] = any;
        w[pos[k] + 1] = all;
      end
      w[14] = nonex;
      w[15] = nonex && nsel == 0;
    end
    w[7] = authd;
    w[6] = busy;
    return w;
  endfunction

  // inputs are stable at the falling edge: compare, then advance the model
  initial forever begin
    @(negedge clk);
    chk("a_valid", {31'b0, a_valid}, {31'b0, ea_v});
    chk("a_word", a_word, ea_w);
    chk("b_valid", {31'b0, b_valid}, {31'b0, eb_v});
    chk("b_word", b_word, eb_w);
    if (!rst_n) begin
      ea_v = 0; eb_v = 0; ea_w = 0; eb_w = 0;
      m_hr = 4'hF; m_ra = 4'h0; m_authd = 0; m_left = 0;
    end else begin
      ea_v = rd;
      eb_v = rd;
      if (rd) begin
        ea_w = model_word(1, 0, m_hr, m_ra);
        eb_w = model_word(m_authd, m_left > 0, m_hr, m_ra);
      end
      for (int i = 0; i < 4; i++)
        if (!dmactive) begin
          m_hr[i] = 1; m_ra[i] = 0;
        end else begin
          if (ack && sel(i)) m_hr[i] = 0;
          if (hreset[i]) m_hr[i] = 1;
          if (hrack[i]) m_ra[i] = 1;
          if (rreq && sel(i)) m_ra[i] = 0;
        end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_authd = m_match;
      end else if (awr) begin
        m_left = 8;
        m_match = adata == 32'hA5A5_5A5A;
      end
    end
  end

  initial begin
    tick(); tick();
    chk("rst_valid", {31'b0, a_valid}, 32'd0);
    chk("rst_word", a_word, 32'd0);
    rst_n = 1; halted = 4'b0001;
    tick();
    rd = 1; tick();
    chk("rd_valid", {31'b0, a_valid}, 32'd1);
    chk("halt0_word", a_word, 32'h004C_0382);
    chk("noauth_word", b_word, 32'h0040_0002);
    tick();
    chk("valid_pulse", {31'b0, a_valid}, 32'd0);
    chk("word_hold", a_word, 32'h004C_0382);
    ack = 1; tick();
    rd = 1; tick();
    chk("ack_hr", (a_word >> 18) & 32'd3, 32'd0);
    ack = 1; hreset = 4'b0001; tick();
    rd = 1; tick();
    chk("set_wins_hr", (a_word >> 18) & 32'd3, 32'd3);
    hasel = 1; hawin = 4'b0011; running = 4'b0010;
    rd = 1; tick();
    chk("window_hr", (a_word >> 8) & 32'hF, 32'h5);
    hasel = 0; hartsel = 7;
    rd = 1; tick();
    chk("nonexist", (a_word >> 8) & 32'hFF, 32'hC0);
    adata = 32'hA5A5_5A5A; awr = 1; tick();
    for (int i = 1; i <= 8; i++) begin
      rd = 1;
      if (i == 4) begin awr = 1; adata = 32'h0; end
      tick();
      chk("authbusy", (b_word >> 6) & 32'd1, 32'd1);
    end
    rd = 1; tick();
    chk("auth_ok", (b_word >> 6) & 32'd3, 32'd2);
    adata = 32'h0; awr = 1; tick();
    repeat (8) tick();
    rd = 1; tick();
    chk("auth_bad", (b_word >> 6) & 32'd3, 32'd0);
    chk("auth_mask", (b_word >> 8) & 32'hFFF, 32'd0);
    hartsel = 0; hrack = 4'b0001; tick();
    rd = 1; tick();
    chk("resumeack_set", (a_word >> 16) & 32'd3, 32'd3);
    rreq = 1; hrack = 4'b0001; tick();
    rd = 1; tick();
    chk("clear_wins_ra", (a_word >> 16) & 32'd3, 32'd0);
    hasel = 1; hawin = 4'b1111; ack = 1; hrack = 4'b1111; tick();
    rd = 1; tick();
    chk("pre_inactive", (a_word >> 16) & 32'hF, 32'h3);
    dmactive = 0; tick();
    dmactive = 1; rd = 1; tick();
    chk("dm_inactive", (a_word >> 16) & 32'hF, 32'hC);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
